stopwatch_lap_core: RTL
=======================

Name: stopwatch_lap_core

Overview:
- Parametrised next-generation stopwatch core. Merges the run/stop/clear control FSM and the time-counter datapath into one block.
- Adds a count-down (timer) mode with preset load and a terminal-count flag.
- Adds a LAP_DEPTH-entry lap-snapshot FIFO that can be read while the watch runs.
- Sits between the debounced button pulses and fnd_controller, and drives its msec/sec/min/hour inputs.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 100, sub-second resolution (ticks per second); msec field counts 0..TICK_HZ-1.
- HOUR_MAX, 24, hour field wraps at HOUR_MAX-1.
- LAP_DEPTH, 4, lap FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- i_runstop  in  1  one-cycle pulse, toggles run/stop
- i_clear  in  1  one-cycle pulse, clears time and lap FIFO
- i_lap  in  1  one-cycle pulse, captures current time into FIFO
- i_lap_rd  in  1  one-cycle pulse, pops FIFO head
- i_mode  in  1  0 = count up, 1 = count down
- i_preset_min  in  6  count-down start minutes (0..59)
- i_preset_sec  in  6  count-down start seconds (0..59)
- o_msec  out  $clog2(TICK_HZ)  current sub-second field
- o_sec  out  6  current seconds
- o_min  out  6  current minutes
- o_hour  out  $clog2(HOUR_MAX)  current hours
- o_running  out  1  high in RUN state
- o_done  out  1  count-down reached zero; sticky until clear
- o_lap_msec / o_lap_sec / o_lap_min / o_lap_hour  out  same widths as time fields  FIFO head (first-word fall-through)
- o_lap_valid  out  1  FIFO non-empty
- o_lap_cnt  out  $clog2(LAP_DEPTH)+1  FIFO occupancy
- o_lap_ovf  out  1  sticky, a lap was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, async):
  - State = STOP.
  - All time fields, prescaler, FIFO pointers, o_lap_cnt, o_done and o_lap_ovf = 0.
  - Latched mode = 0.
  - Lap head outputs = 0.
- FSM states: STOP, RUN, DONE.
  - STOP + i_runstop -> RUN. Latch i_mode at this transition.
  - In down mode, if the time is all-zero at that transition, go to DONE instead and set o_done.
  - RUN + i_runstop -> STOP.
  - RUN + down mode + terminal decrement -> DONE.
  - DONE + i_runstop -> no change.
  - Any state + i_clear -> STOP.
- Same-cycle input priority: i_clear > i_runstop > i_lap. An i_lap coinciding with i_clear is discarded.
- Clear, effective next edge:
  - FIFO emptied; o_lap_ovf = 0; o_done = 0.
  - Latched mode <- i_mode.
  - Up mode: time = 0.
  - Down mode: hour = 0, min = i_preset_min, sec = i_preset_sec, msec = 0.
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1 only in RUN; held at 0 otherwise, so resume always starts a full period.
  - tick = terminal count in RUN.
- Up count on tick:
  - msec increments and wraps at TICK_HZ-1 with carry into sec.
  - sec and min wrap at 59 with carry to the next field.
  - hour wraps HOUR_MAX-1 -> 0 with no flag.
- Down count on tick:
  - Decrement with borrow; msec 0 -> TICK_HZ-1 and borrow from sec; sec and min 0 -> 59.
  - The tick that brings all fields to 0 moves the FSM to DONE and sets o_done the same edge.
  - Counter holds at 0 afterwards; no underflow.
- Lap FIFO:
  - i_lap in RUN or STOP pushes the registered time value present at that clock (pre-tick value if a tick coincides).
  - Push when full: entry dropped, o_lap_ovf = 1, contents unchanged.
  - i_lap_rd when empty: ignored.
  - Simultaneous push and pop when full: both occur, o_lap_cnt unchanged, no overflow.
  - Simultaneous push and pop when empty: push only.
  - Head outputs update the cycle after a push into an empty FIFO, and the cycle after a pop.
  - Head outputs are 0 when empty.
- Mode change while RUN has no effect until the next clear or STOP->RUN transition.
- Reset asserted mid-count: immediate return to reset values; no partial update.

Test Plan:
- Use CLK_HZ=1000, TICK_HZ=100 (10-clock tick) for all scenarios.
- Reset, then i_runstop, wait 1000 clocks -> sec=1, msec=0, o_running=1. i_runstop -> o_running=0; values frozen over 500 clocks.
- Force time to 0:59:59.99 (up mode) and run 10 clocks -> min=1, sec=0, msec=0. Force to 23:59:59.99 and run 10 clocks -> all fields 0.
- Down mode: preset 0:02 and clear -> sec=2, msec=0. Run 2000 clocks -> all 0, o_done=1, state DONE. Further i_runstop -> no change. i_clear -> o_done=0, sec=2.
- Push 5 laps at times 10, 20, 30, 40, 50 ticks (LAP_DEPTH=4) -> o_lap_cnt=4, o_lap_ovf=1, head msec=10. Pop -> head msec=20, cnt=3. Push and pop in the same cycle when full -> cnt stays 4.
- Assert i_clear and i_lap in the same cycle while running -> time=0, FIFO empty, STOP, no overflow. Assert reset mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_lap_core.sv
// Stopwatch/count-down timer with run/stop/clear FSM, time datapath and lap-snapshot FIFO.
// One-cycle latency on every control pulse; no backpressure: a lap pushed while full is dropped and flagged.
module stopwatch_lap_core #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int HOUR_MAX  = 24,
    parameter int LAP_DEPTH = 4,
    localparam int MS_W  = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1,
    localparam int HR_W  = (HOUR_MAX > 1) ? $clog2(HOUR_MAX) : 1,
    localparam int CNT_W = $clog2(LAP_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_runstop,
    input  logic             i_clear,
    input  logic             i_lap,
    input  logic             i_lap_rd,
    input  logic             i_mode,
    input  logic [5:0]       i_preset_min,
    input  logic [5:0]       i_preset_sec,
    output logic [MS_W-1:0]  o_msec,
    output logic [5:0]       o_sec,
    output logic [5:0]       o_min,
    output logic [HR_W-1:0]  o_hour,
    output logic             o_running,
    output logic             o_done,
    output logic [MS_W-1:0]  o_lap_msec,
    output logic [5:0]       o_lap_sec,
    output logic [5:0]       o_lap_min,
    output logic [HR_W-1:0]  o_lap_hour,
    output logic             o_lap_valid,
    output logic [CNT_W-1:0] o_lap_cnt,
    output logic             o_lap_ovf
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int PTR_W    = $clog2(LAP_DEPTH);

    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [MS_W-1:0]  MS_LAST = MS_W'(TICK_HZ - 1);
    localparam logic [HR_W-1:0]  HR_LAST = HR_W'(HOUR_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DONE} state_t;

    typedef struct packed {
        logic [HR_W-1:0] hour;
        logic [5:0]      min;
        logic [5:0]      sec;
        logic [MS_W-1:0] msec;
    } lap_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic            done_q, done_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [MS_W-1:0] msec_q, msec_d;
    logic [5:0]      sec_q, sec_d;
    logic [5:0]      min_q, min_d;
    logic [HR_W-1:0] hour_q, hour_d;

    logic tick;
    logic time_zero;
    logic one_left;

    lap_t             lap_mem [LAP_DEPTH];
    lap_t             cur_time;
    lap_t             lap_head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] lap_cnt;
    logic             lap_ovf;
    logic             push_req, push, pop, lap_full;

    assign tick      = (state_q == ST_RUN) && (ps_q == PS_LAST);
    assign time_zero = (msec_q == '0) && (sec_q == '0) && (min_q == '0) && (hour_q == '0);
    assign one_left  = (msec_q == MS_W'(1)) && (sec_q == '0) && (min_q == '0) && (hour_q == '0);

    // Control FSM: clear wins over run/stop, terminal decrement lands in DONE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        done_d  = done_q;
        if (i_clear) begin
            state_d = ST_STOP;
            mode_d  = i_mode;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (i_runstop) begin
                        mode_d = i_mode;
                        if (i_mode && time_zero) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_runstop) begin
                        state_d = ST_STOP;
                    end else if (tick && mode_q && one_left) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: ;
                default: state_d = ST_STOP;
            endcase
        end
    end

    always_comb begin
        ps_d = '0;
        if (!i_clear && state_q == ST_RUN && !tick) begin
            ps_d = ps_q + 1'b1;
        end
    end

    // Time datapath: preset/zero on clear, carry chain up or borrow chain down on tick.
    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (i_clear) begin
            msec_d = '0;
            hour_d = '0;
            sec_d  = i_mode ? i_preset_sec : 6'd0;
            min_d  = i_mode ? i_preset_min : 6'd0;
        end else if (tick) begin
            if (!mode_q) begin
                if (msec_q == MS_LAST) begin
                    msec_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d  = '0;
                            hour_d = (hour_q == HR_LAST) ? '0 : hour_q + 1'b1;
                        end else begin
                            min_d = min_q + 1'b1;
                        end
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end else begin
                    msec_d = msec_q + 1'b1;
                end
            end else if (!time_zero) begin
                if (msec_q != '0) begin
                    msec_d = msec_q - 1'b1;
                end else begin
                    msec_d = MS_LAST;
                    if (sec_q != '0) begin
                        sec_d = sec_q - 1'b1;
                    end else begin
                        sec_d = 6'd59;
                        if (min_q != '0) begin
                            min_d = min_q - 1'b1;
                        end else begin
                            min_d  = 6'd59;
                            hour_d = hour_q - 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STOP;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            ps_q    <= '0;
            msec_q  <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            ps_q    <= ps_d;
            msec_q  <= msec_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
        end
    end

    // Lap FIFO: snapshot is the registered (pre-tick) time; a pop frees room for a same-cycle push.
    assign cur_time = {hour_q, min_q, sec_q, msec_q};
    assign lap_full = (lap_cnt == CNT_FULL);
    assign push_req = i_lap && !i_clear && (state_q != ST_DONE);
    assign pop      = i_lap_rd && !i_clear && (lap_cnt != '0);
    assign push     = push_req && (!lap_full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lap_cnt <= '0;
            lap_ovf <= 1'b0;
        end else if (i_clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lap_cnt <= '0;
            lap_ovf <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                lap_cnt <= lap_cnt + 1'b1;
            end else if (pop && !push) begin
                lap_cnt <= lap_cnt - 1'b1;
            end
            if (push_req && lap_full && !pop) begin
                lap_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lap_mem[wr_ptr] <= cur_time;
        end
    end

    assign lap_head = (lap_cnt != '0) ? lap_mem[rd_ptr] : '0;

    assign o_msec      = msec_q;
    assign o_sec       = sec_q;
    assign o_min       = min_q;
    assign o_hour      = hour_q;
    assign o_running   = (state_q == ST_RUN);
    assign o_done      = done_q;
    assign o_lap_msec  = lap_head.msec;
    assign o_lap_sec   = lap_head.sec;
    assign o_lap_min   = lap_head.min;
    assign o_lap_hour  = lap_head.hour;
    assign o_lap_valid = (lap_cnt != '0);
    assign o_lap_cnt   = lap_cnt;
    assign o_lap_ovf   = lap_ovf;

endmodule
